// File: rtl/tdd_ng_sequencer.sv
// Frame-counter based TDD timing sequencer: startup delay, burst-limited or
// free-running frames, resync, and per-channel on/off windows that may wrap.
module tdd_ng_sequencer #(
  parameter int CHANNEL_COUNT     = 8,
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     enable,
  input  logic                                     sync_int,
  input  logic                                     sync_ext,
  input  logic                                     sync_soft,
  input  logic                                     sync_rst,
  input  logic [BURST_COUNT_WIDTH-1:0]             burst_count,
  input  logic [REGISTER_WIDTH-1:0]                startup_delay,
  input  logic [REGISTER_WIDTH-1:0]                frame_length,
  input  logic [CHANNEL_COUNT-1:0]                 ch_en,
  input  logic [CHANNEL_COUNT-1:0]                 ch_pol,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  ch_on,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  ch_off,
  output logic [CHANNEL_COUNT-1:0]                 tdd_channel,
  output logic [1:0]                               tdd_cstate,
  output logic [REGISTER_WIDTH-1:0]                tdd_counter,
  output logic                                     tdd_endof_frame
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    WAITING = 2'b10,
    RUNNING = 2'b11
  } state_t;

  localparam logic [REGISTER_WIDTH-1:0]    CNT_ONE   = REGISTER_WIDTH'(1);
  localparam logic [BURST_COUNT_WIDTH-1:0] BURST_ONE = BURST_COUNT_WIDTH'(1);

  state_t                         state;
  state_t                         start_state;
  logic [REGISTER_WIDTH-1:0]      counter;
  logic [BURST_COUNT_WIDTH-1:0]   frames_left;
  logic                           sync_ext_d;
  logic [CHANNEL_COUNT-1:0]       raw;
  logic [CHANNEL_COUNT-1:0]       raw_next;
  logic [CHANNEL_COUNT-1:0]       on_hit;
  logic [CHANNEL_COUNT-1:0]       off_hit;
  logic                           sync_event;
  logic                           restart;
  logic                           end_of_frame;
  logic                           last_frame;
  logic                           wait_done;

  assign sync_event   = (sync_ext & ~sync_ext_d) | sync_soft | (sync_int & (state == ARMED));
  assign restart      = sync_rst & sync_event & ((state == WAITING) | (state == RUNNING));
  assign end_of_frame = (state == RUNNING) && (counter == frame_length);
  // frames_left == 0 means free-running, so only a count of exactly one ends the burst
  assign last_frame   = end_of_frame && (frames_left == BURST_ONE);
  assign wait_done    = (counter == (startup_delay - CNT_ONE));
  assign start_state  = (startup_delay != '0) ? WAITING : RUNNING;

  generate
    for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_window
      assign on_hit[gi]  = (counter == ch_on[gi*REGISTER_WIDTH +: REGISTER_WIDTH]);
      assign off_hit[gi] = (counter == ch_off[gi*REGISTER_WIDTH +: REGISTER_WIDTH]);
    end
  endgenerate

  // Raw window state is held across the frame boundary so on > off wraps.
  always_comb begin
    raw_next = '0;
    if (enable && (state == RUNNING) && !restart && !last_frame) begin
      raw_next = (raw | on_hit) & ~off_hit;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      counter     <= '0;
      frames_left <= '0;
      sync_ext_d  <= 1'b0;
    end else begin
      sync_ext_d <= sync_ext;
      if (!enable) begin
        state   <= IDLE;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARMED;
            counter <= '0;
          end
          ARMED: begin
            if (sync_event) begin
              frames_left <= burst_count;
              counter     <= '0;
              state       <= start_state;
            end
          end
          WAITING: begin
            if (restart) begin
              frames_left <= burst_count;
              counter     <= '0;
              state       <= start_state;
            end else if (wait_done) begin
              counter <= '0;
              state   <= RUNNING;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          RUNNING: begin
            if (restart) begin
              frames_left <= burst_count;
              counter     <= '0;
              state       <= start_state;
            end else if (end_of_frame) begin
              counter <= '0;
              if (frames_left != '0) begin
                frames_left <= frames_left - BURST_ONE;
              end
              if (last_frame) begin
                state <= IDLE;
              end
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw         <= '0;
      tdd_channel <= '0;
    end else begin
      raw         <= raw_next;
      tdd_channel <= (raw_next & ch_en) ^ ch_pol;
    end
  end

  assign tdd_cstate      = state;
  assign tdd_counter     = counter;
  assign tdd_endof_frame = end_of_frame;

endmodule

// File: tb/tb_tdd_ng_sequencer.sv
// Scoreboard bench for tdd_ng_sequencer: a behavioural model pushes the
// expected outputs each clock, a monitor pops and compares on the falling edge.
module tb_tdd_ng_sequencer;
  localparam int CH = 4;
  localparam int RW = 8;
  localparam int BW = 16;

  logic            clk;
  logic            resetn;
  logic            enable, sync_int, sync_ext, sync_soft, sync_rst;
  logic [BW-1:0]   burst_count;
  logic [RW-1:0]   startup_delay, frame_length;
  logic [CH-1:0]   ch_en, ch_pol;
  logic [CH*RW-1:0] ch_on, ch_off;
  logic [CH-1:0]   tdd_channel;
  logic [1:0]      tdd_cstate;
  logic [RW-1:0]   tdd_counter;
  logic            tdd_endof_frame;

  int tests = 0;
  int fails = 0;

  tdd_ng_sequencer #(.CHANNEL_COUNT(CH), .REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .sync_int(sync_int), .sync_ext(sync_ext),
    .sync_soft(sync_soft), .sync_rst(sync_rst), .burst_count(burst_count),
    .startup_delay(startup_delay), .frame_length(frame_length), .ch_en(ch_en), .ch_pol(ch_pol),
    .ch_on(ch_on), .ch_off(ch_off), .tdd_channel(tdd_channel), .tdd_cstate(tdd_cstate),
    .tdd_counter(tdd_counter), .tdd_endof_frame(tdd_endof_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] ch;
    logic [1:0]    st;
    logic [RW-1:0] cnt;
    logic          eof;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e, mon_e;

  // Reference model: phase 0..3 = IDLE/ARMED/WAITING/RUNNING, position within phase.
  int        m_phase, m_pos, m_left;
  bit [CH-1:0] m_raw, m_out;
  bit        m_prev;

  task automatic begin_sequence();
    m_left  = int'(burst_count);
    m_pos   = 0;
    m_raw   = '0;
    m_phase = (startup_delay != 0) ? 2 : 3;
  endtask

  task automatic model_step();
    bit ev;
    ev = (sync_ext && !m_prev) || sync_soft || (sync_int && m_phase == 1);
    m_prev = sync_ext;
    if (!enable) begin
      m_phase = 0; m_pos = 0; m_raw = '0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_pos = 0;
    end else if (m_phase == 1) begin
      if (ev) begin_sequence();
    end else if (sync_rst && ev) begin
      begin_sequence();
    end else if (m_phase == 2) begin
      if (m_pos + 1 == int'(startup_delay)) begin m_phase = 3; m_pos = 0; end
      else m_pos++;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (m_pos == int'(ch_off[i*RW +: RW])) m_raw[i] = 1'b0;
        else if (m_pos == int'(ch_on[i*RW +: RW])) m_raw[i] = 1'b1;
      end
      if (m_pos == int'(frame_length)) begin
        m_pos = 0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin m_phase = 0; m_raw = '0; end
        end
      end else begin
        m_pos++;
      end
    end
    m_out = (m_raw & ch_en) ^ ch_pol;
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      m_phase = 0; m_pos = 0; m_left = 0; m_raw = '0; m_prev = 1'b0; m_out = '0;
    end else begin
      model_step();
    end
    m_e.ch  = m_out;
    m_e.st  = 2'(m_phase);
    m_e.cnt = RW'(m_pos);
    m_e.eof = (m_phase == 3) && (m_pos == int'(frame_length));
    exp_q.push_back(m_e);
  end

  // Monitor: one expected entry per cycle, compared on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: no expected entry at t=%0t, got st=%0d cnt=%0d", $time, tdd_cstate, tdd_counter);
      end else begin
        mon_e = exp_q.pop_front();
        if (!resetn) begin
          mon_e.ch = '0; mon_e.st = 2'd0; mon_e.cnt = '0; mon_e.eof = 1'b0;
        end
        if ({tdd_channel, tdd_cstate, tdd_counter, tdd_endof_frame} !==
            {mon_e.ch, mon_e.st, mon_e.cnt, mon_e.eof}) begin
          fails++;
          $display("FAIL cycle t=%0t: got ch=%b st=%0d cnt=%0d eof=%b, expected ch=%b st=%0d cnt=%0d eof=%b",
                   $time, tdd_channel, tdd_cstate, tdd_counter, tdd_endof_frame,
                   mon_e.ch, mon_e.st, mon_e.cnt, mon_e.eof);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_for(input logic [1:0] st, input int cnt, input int budget, input string name);
    int n;
    n = 0;
    while (!(tdd_cstate == st && (cnt < 0 || int'(tdd_counter) == cnt)) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check({name, "_reached"}, tdd_cstate, st);
  endtask

  task automatic idle_config(input int fl, input int dly, input int burst);
    enable = 1'b0; sync_soft = 1'b0; sync_int = 1'b0; sync_ext = 1'b0;
    tick(); tick();
    frame_length = RW'(fl); startup_delay = RW'(dly); burst_count = BW'(burst);
  endtask

  task automatic soft_start(input string name);
    enable = 1'b1;
    wait_for(2'd1, -1, 10, name);
    sync_soft = 1'b1;
    tick();
    sync_soft = 1'b0;
  endtask

  int n_wait, n_eof, n_hi, n;

  initial begin
    resetn = 1'b0; enable = 1'b0; sync_int = 1'b0; sync_ext = 1'b0; sync_soft = 1'b0;
    sync_rst = 1'b0; burst_count = '0; startup_delay = '0; frame_length = '0;
    ch_en = '0; ch_pol = '0; ch_on = '0; ch_off = '0;
    tick(); tick();
    check("reset_cstate", tdd_cstate, 0);
    check("reset_counter", tdd_counter, 0);
    resetn = 1'b1;

    // Basic burst: delay 3, two 10-cycle frames, ch0 window 2..5
    idle_config(9, 3, 2);
    ch_en = 4'b0001; ch_pol = 4'b0000;
    ch_on[0 +: RW] = 8'd2; ch_off[0 +: RW] = 8'd5;
    soft_start("s1_armed");
    n_wait = 0; n_eof = 0; n_hi = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      if (tdd_cstate == 2'd2) n_wait++;
      if (tdd_endof_frame) n_eof++;
      if (tdd_channel[0]) n_hi++;
    end
    check("s1_waiting_cycles", n_wait, 3);
    check("s1_eof_pulses", n_eof, 2);
    check("s1_ch0_high_cycles", n_hi, 6);
    check("s1_rearmed", tdd_cstate, 1);

    // Wrapping window on ch1, free-running
    idle_config(9, 0, 0);
    ch_en = 4'b0010;
    ch_on[1*RW +: RW] = 8'd8; ch_off[1*RW +: RW] = 8'd2;
    soft_start("s2_armed");
    repeat (12) tick();
    n_hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (tdd_channel[1]) n_hi++;
    end
    check("s2_ch1_high_3frames", n_hi, 12);
    check("s2_still_running", tdd_cstate, 3);

    // Polarity with channel disabled, across an asynchronous reset
    idle_config(9, 0, 0);
    ch_en = 4'b0000; ch_pol = 4'b0100;
    tick();
    check("s3_pol_idle", tdd_channel, 4'b0100);
    #2 resetn = 1'b0;
    #1 check("s3_reset_async", tdd_channel, 0);
    tick();
    check("s3_reset_cstate", tdd_cstate, 0);
    resetn = 1'b1;
    tick();
    check("s3_pol_after_reset", tdd_channel, 4'b0100);
    ch_pol = 4'b0000;

    // Resync with sync_rst=1 restarts the burst; with sync_rst=0 it is ignored
    for (int r = 1; r >= 0; r--) begin
      idle_config(9, 0, 3);
      sync_rst = r[0];
      soft_start("s4_armed");
      wait_for(2'd3, 6, 20, "s4_cnt6");
      sync_ext = 1'b1;
      tick();
      sync_ext = 1'b0;
      n = 1;
      while (tdd_cstate != 2'd0 && n < 60) begin
        tick();
        n++;
      end
      check(r == 1 ? "s4_resync_len" : "s4_ignored_len", n, r == 1 ? 31 : 24);
    end
    sync_rst = 1'b0;

    // Enable dropped mid-frame
    idle_config(9, 0, 0);
    ch_en = 4'b0011; ch_pol = 4'b0100;
    ch_on[0 +: RW] = 8'd2; ch_off[0 +: RW] = 8'd5;
    soft_start("s5_armed");
    wait_for(2'd3, 4, 20, "s5_cnt4");
    check("s5_ch0_high_before", tdd_channel[0], 1);
    enable = 1'b0;
    tick();
    check("s5_cstate_idle", tdd_cstate, 0);
    check("s5_counter_zero", tdd_counter, 0);
    check("s5_no_eof", tdd_endof_frame, 0);
    check("s5_channels", tdd_channel, 4'b0100);
    ch_pol = 4'b0000;

    // Zero delay, one-cycle frames, internal sync
    idle_config(0, 0, 5);
    sync_int = 1'b1;
    enable = 1'b1;
    wait_for(2'd3, -1, 10, "s6_running");
    n_eof = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (tdd_endof_frame) n_eof++;
    end
    check("s6_eof_consecutive", n_eof, 5);
    tick();
    check("s6_idle_after_burst", tdd_cstate, 0);
    sync_int = 1'b0;

    // Randomised episodes; config changes only while disabled
    for (int ep = 0; ep < 150; ep++) begin
      idle_config($urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 4));
      for (int i = 0; i < CH; i++) begin
        ch_on[i*RW +: RW]  = RW'($urandom_range(0, 13));
        ch_off[i*RW +: RW] = RW'($urandom_range(0, 13));
      end
      ch_en = CH'($urandom); ch_pol = CH'($urandom);
      sync_rst = $urandom_range(0, 1) == 1;
      enable = 1'b1;
      repeat ($urandom_range(20, 80)) begin
        tick();
        sync_soft = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0) sync_ext = ~sync_ext;
        if ($urandom_range(0, 31) == 0) sync_int = ~sync_int;
        if ($urandom_range(0, 39) == 0) ch_en = CH'($urandom);
        if ($urandom_range(0, 39) == 0) ch_pol = CH'($urandom);
        enable = ($urandom_range(0, 59) != 0);
        if ($urandom_range(0, 199) == 0) begin
          #2 resetn = 1'b0;
          tick();
          resetn = 1'b1;
        end
      end
    end

    enable = 1'b0; sync_soft = 1'b0;
    tick(); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
